// File: rtl/vga_rx_if.sv
// Bundle between a VGA sync/colour source and the receiver: raw stream in, recovered pixels and status out.
interface vga_rx_if;
  // No ready/backpressure: the stream advances every clk; pixel_valid qualifies x/y/color_out for that one cycle only.
  logic        hsync;
  logic        vsync;
  logic [11:0] color_in;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] color_out;
  logic        frame_start;
  logic        locked;
  logic [10:0] h_total;
  logic [9:0]  v_total;

  modport master (
    output hsync, vsync, color_in,
    input  pixel_valid, x, y, color_out, frame_start, locked, h_total, v_total
  );

  modport slave (
    input  hsync, vsync, color_in,
    output pixel_valid, x, y, color_out, frame_start, locked, h_total, v_total
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from an hsync/vsync/colour stream, measures line/frame totals
// and qualifies the stream with a SEARCH/TRAIN/LOCKED state machine.
module vga_sync_receiver #(
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480,
  parameter int H_MAX       = 1023,
  parameter int V_MAX       = 1023,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  vga_rx_if.slave    vga,
  output logic [1:0] dbg_state
);

  localparam logic [1:0]  S_SEARCH = 2'd0;
  localparam logic [1:0]  S_TRAIN  = 2'd1;
  localparam logic [1:0]  S_LOCKED = 2'd2;

  localparam logic [10:0] H_SAT  = 11'h7ff;
  localparam logic [9:0]  V_SAT  = 10'h3ff;
  localparam logic [10:0] H_LO   = 11'(H_START);
  localparam logic [10:0] H_HI   = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO   = 10'(V_START);
  localparam logic [9:0]  V_HI   = 10'(V_START + V_ACTIVE);
  localparam logic [10:0] H_TMO  = 11'(H_MAX);
  localparam logic [9:0]  V_TMO  = 10'(V_MAX);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  logic        hs1, hs1_d, vs1, vs_ls;
  logic [11:0] col1;
  logic [10:0] h_cnt, ref_h, prev_h;
  logic [9:0]  v_cnt, prev_v;
  logic        frame_ok;
  logic [7:0]  match_cnt, match_nxt;
  logic [1:0]  state, state_nxt;

  logic        line_start, fs_det, h_tmo, v_tmo, line_bad, frame_cons, active;
  logic [10:0] line_len, h_idx, frame_h;
  logic [9:0]  frame_len, v_idx;

  assign dbg_state = state;

  always_comb begin
    line_start = hs1_d & ~hs1;
    // vs_ls holds vsync as seen at the previous line start, so a frame begins on its first low line
    fs_det     = line_start & ~vs1 & vs_ls;
    line_len   = (h_cnt == H_SAT) ? H_SAT : h_cnt + 11'd1;
    frame_len  = (v_cnt == V_SAT) ? V_SAT : v_cnt + 10'd1;
    h_idx      = line_start ? 11'd0 : line_len;
    if (fs_det)          v_idx = 10'd0;
    else if (line_start) v_idx = frame_len;
    else                 v_idx = v_cnt;
    h_tmo      = !line_start && (h_idx == H_TMO);
    v_tmo      = line_start && !fs_det && (v_idx == V_TMO);
    // The first line of a frame sets the reference length the rest of the frame must match
    line_bad   = line_start && (v_cnt != 10'd0) && (line_len != ref_h);
    frame_cons = frame_ok && !line_bad;
    frame_h    = (v_cnt == 10'd0) ? line_len : ref_h;

    state_nxt = state;
    match_nxt = match_cnt;
    case (state)
      S_SEARCH: begin
        if (fs_det) begin
          state_nxt = S_TRAIN;
          match_nxt = 8'd0;
        end
      end
      S_TRAIN: begin
        if (fs_det) begin
          if (frame_cons && ((match_cnt == 8'd0) || ((frame_h == prev_h) && (frame_len == prev_v))))
            match_nxt = match_cnt + 8'd1;
          else
            match_nxt = frame_cons ? 8'd1 : 8'd0;
          if (match_nxt == LOCK_N) state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if ((line_start && (line_len != prev_h)) || (fs_det && (frame_len != prev_v)) || h_tmo || v_tmo)
          state_nxt = S_SEARCH;
      end
      default: state_nxt = S_SEARCH;
    endcase

    active = (state_nxt == S_LOCKED) &&
             (h_idx >= H_LO) && (h_idx < H_HI) &&
             (v_idx >= V_LO) && (v_idx < V_HI);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs1             <= 1'b0;
      hs1_d           <= 1'b0;
      vs1             <= 1'b1;
      vs_ls           <= 1'b0;
      col1            <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      ref_h           <= '0;
      prev_h          <= '0;
      prev_v          <= '0;
      frame_ok        <= 1'b0;
      match_cnt       <= '0;
      state           <= S_SEARCH;
      vga.pixel_valid <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.locked      <= 1'b0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.color_out   <= '0;
      vga.h_total     <= '0;
      vga.v_total     <= '0;
    end else begin
      hs1       <= vga.hsync;
      hs1_d     <= hs1;
      vs1       <= vga.vsync;
      col1      <= vga.color_in;
      h_cnt     <= h_idx;
      v_cnt     <= v_idx;
      state     <= state_nxt;
      match_cnt <= match_nxt;

      if (line_start) begin
        vs_ls       <= vs1;
        vga.h_total <= line_len;
        if (v_cnt == 10'd0) ref_h <= line_len;
      end

      if (fs_det) begin
        vga.v_total <= frame_len;
        frame_ok    <= 1'b1;
      end else if (line_bad || h_tmo || v_tmo) begin
        frame_ok <= 1'b0;
      end

      if ((state == S_TRAIN) && fs_det) begin
        prev_h <= frame_h;
        prev_v <= frame_len;
      end

      vga.locked      <= (state_nxt == S_LOCKED);
      vga.pixel_valid <= active;
      vga.frame_start <= active && (h_idx == H_LO) && (v_idx == V_LO);
      if (active) begin
        vga.x         <= 10'(h_idx - H_LO);
        vga.y         <= v_idx - V_LO;
        vga.color_out <= col1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down 20x10 raster: frame table plus hand sequences for
// short line, hsync stall, extra line and asynchronous reset.
module tb_vga_sync_receiver;

  localparam int HT = 20, VT = 10, HS_W = 4, VS_W = 2;
  localparam int H_START = 6, H_ACTIVE = 8, V_START = 3, V_ACTIVE = 4;
  localparam int H_MAX = 63, V_MAX = 31;
  localparam int W = 33;

  typedef struct {
    int lines;
    int exp_locked;
    int exp_pv;
    int exp_fs;
    int exp_h;
    int exp_v;
  } frame_vec_t;

  logic         clk, rst;
  logic [1:0]   dbg_state;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_rec;
  int           n_total, n_pass, pv_cnt, fs_cnt;

  vga_rx_if vga();

  vga_sync_receiver #(
    .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE),
    .H_MAX(H_MAX), .V_MAX(V_MAX), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // driver: one sample per clock; every sample's expected pixel goes into the scoreboard queue
  task automatic drive_sample(input logic hs, input logic vs, input int row, input int s);
    logic        ga;
    logic [9:0]  ex, ey;
    logic [11:0] col;
    @(posedge clk);
    #2;
    ga  = (row >= V_START) && (row < V_START + V_ACTIVE) && (s >= H_START) && (s < H_START + H_ACTIVE);
    ex  = ga ? 10'(s - H_START) : 10'd0;
    ey  = ga ? 10'(row - V_START) : 10'd0;
    col = ga ? {ex[3:0], ey[3:0], 4'hA} : 12'h555;
    vga.hsync    = hs;
    vga.vsync    = vs;
    vga.color_in = col;
    exp_q.push_back({ga, ex, ey, col});
  endtask

  // vsync falls together with hsync on row 0, so every frame exercises the coincident edge
  task automatic drive_line(input int row, input int len);
    for (int s = 0; s < len; s++) drive_sample(s >= HS_W, row >= VS_W, row, s);
  endtask

  task automatic drive_frame(input int lines);
    for (int r = 0; r < lines; r++) drive_line(r, HT);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pixel_valid"}, int'(vga.pixel_valid), 0);
    check({tag, "_frame_start"}, int'(vga.frame_start), 0);
    check({tag, "_locked"},      int'(vga.locked), 0);
    check({tag, "_x"},           int'(vga.x), 0);
    check({tag, "_y"},           int'(vga.y), 0);
    check({tag, "_color_out"},   int'(vga.color_out), 0);
    check({tag, "_h_total"},     int'(vga.h_total), 0);
    check({tag, "_v_total"},     int'(vga.v_total), 0);
    check({tag, "_state"},       int'(dbg_state), 0);
  endtask

  // caller clears pv_cnt at the point from which no pixel may appear
  task automatic relock_check(input string tag);
    drive_frame(VT);
    drive_frame(VT);
    check({tag, "_pv_before_relock"}, pv_cnt, 0);
    check({tag, "_locked_train"},     int'(vga.locked), 0);
    check({tag, "_state_train"},      int'(dbg_state), 1);
    pv_cnt = 0;
    fs_cnt = 0;
    drive_frame(VT);
    check({tag, "_relocked"}, int'(vga.locked), 1);
    check({tag, "_relock_pv"}, pv_cnt, H_ACTIVE * V_ACTIVE);
    check({tag, "_relock_fs"}, fs_cnt, 1);
  endtask

  // scoreboard: output at cycle c belongs to the sample driven at cycle c-2
  always @(negedge clk) begin
    if (exp_q.size() >= 3) begin
      mon_rec = exp_q.pop_front();
      if (vga.pixel_valid) begin
        pv_cnt++;
        n_total++;
        if (mon_rec[32] && vga.x == mon_rec[31:22] && vga.y == mon_rec[21:12] && vga.color_out == mon_rec[11:0])
          n_pass++;
        else
          $display("FAIL pixel: got x=%0d y=%0d color=%h, expected active=%0b x=%0d y=%0d color=%h",
                   vga.x, vga.y, vga.color_out, mon_rec[32], mon_rec[31:22], mon_rec[21:12], mon_rec[11:0]);
      end
      if (vga.frame_start) begin
        fs_cnt++;
        n_total++;
        if (vga.pixel_valid && mon_rec[32] && mon_rec[31:22] == 10'd0 && mon_rec[21:12] == 10'd0)
          n_pass++;
        else
          $display("FAIL frame_start: got pulse at x=%0d y=%0d valid=%0b, expected only at pixel (0,0)",
                   mon_rec[31:22], mon_rec[21:12], vga.pixel_valid);
      end
    end
  end

  initial begin
    frame_vec_t tbl[9];
    tbl[0] = '{VT,     0, 0,  0, 20, -1};
    tbl[1] = '{VT,     0, 0,  0, 20, 10};
    tbl[2] = '{VT,     1, 32, 1, 20, 10};
    tbl[3] = '{VT,     1, 32, 1, 20, 10};
    tbl[4] = '{VT + 1, 1, 32, 1, 20, 10};
    tbl[5] = '{VT,     0, 0,  0, 20, 11};
    tbl[6] = '{VT,     0, 0,  0, 20, 10};
    tbl[7] = '{VT,     0, 0,  0, 20, 10};
    tbl[8] = '{VT,     1, 32, 1, 20, 10};

    n_total = 0;
    n_pass  = 0;
    pv_cnt  = 0;
    fs_cnt  = 0;
    rst          = 1'b0;
    vga.hsync    = 1'b1;
    vga.vsync    = 1'b1;
    vga.color_in = 12'h000;

    // reset held over row 4, released mid-frame
    drive_line(4, HT);
    check_reset("reset");
    rst = 1'b1;
    for (int r = 5; r < VT; r++) drive_line(r, HT);

    for (int i = 0; i < 9; i++) begin
      pv_cnt = 0;
      fs_cnt = 0;
      drive_frame(tbl[i].lines);
      check($sformatf("tbl%0d_locked", i), int'(vga.locked), tbl[i].exp_locked);
      check($sformatf("tbl%0d_pv", i), pv_cnt, tbl[i].exp_pv);
      check($sformatf("tbl%0d_fs", i), fs_cnt, tbl[i].exp_fs);
      check($sformatf("tbl%0d_h_total", i), int'(vga.h_total), tbl[i].exp_h);
      if (tbl[i].exp_v >= 0) check($sformatf("tbl%0d_v_total", i), int'(vga.v_total), tbl[i].exp_v);
    end

    // short line (19 samples) on row 5 while locked
    pv_cnt = 0;
    for (int r = 0; r < 5; r++) drive_line(r, HT);
    drive_line(5, HT - 1);
    drive_sample(1'b0, 1'b1, 6, 0);
    drive_sample(1'b0, 1'b1, 6, 1);
    check("short_locked_t1", int'(vga.locked), 1);
    drive_sample(1'b0, 1'b1, 6, 2);
    check("short_locked_t2", int'(vga.locked), 0);
    for (int s = 3; s < HT; s++) drive_sample(s >= HS_W, 1'b1, 6, s);
    for (int r = 7; r < VT; r++) drive_line(r, HT);
    check("short_pv", pv_cnt, 24);
    check("short_state", int'(dbg_state), 0);
    pv_cnt = 0;
    relock_check("short");

    // hsync stuck high after the row-4 line start
    pv_cnt = 0;
    for (int r = 0; r < 4; r++) drive_line(r, HT);
    drive_line(4, H_MAX + 2);
    check("stall_locked_t64", int'(vga.locked), 1);
    drive_sample(1'b1, 1'b1, 4, H_MAX + 2);
    check("stall_locked_t65", int'(vga.locked), 0);
    check("stall_pv_row", pv_cnt, 16);
    pv_cnt = 0;
    for (int s = H_MAX + 3; s < 81; s++) drive_sample(1'b1, 1'b1, 4, s);
    relock_check("stall");

    // asynchronous reset in the middle of an active line
    for (int r = 0; r < 4; r++) drive_line(r, HT);
    for (int s = 0; s < 10; s++) drive_sample(s >= HS_W, 1'b1, 4, s);
    check("prereset_pixel_valid", int'(vga.pixel_valid), 1);
    #1 rst = 1'b0;
    #1 check_reset("midline_reset");
    for (int s = 10; s < 13; s++) drive_sample(s >= HS_W, 1'b1, 4, s);
    rst = 1'b1;
    pv_cnt = 0;
    for (int s = 13; s < HT; s++) drive_sample(s >= HS_W, 1'b1, 4, s);
    for (int r = 5; r < VT; r++) drive_line(r, HT);
    relock_check("reset");
    check("final_h_total", int'(vga.h_total), HT);
    check("final_v_total", int'(vga.v_total), VT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Pixel-clock-domain VGA receiver: consumes an hsync/vsync/12-bit colour stream of the kind produced by the `vga` timing generator and recovers pixel coordinates, measures line/frame totals, and qualifies the stream with a lock state machine. It sits at the input edge of a capture or loopback-check path. It delivers `x`/`y`/colour for active pixels only while locked.

## Interface
- `H_START`, 144: sample index (from hsync fall) of first active pixel (sync 96 + back porch 48)
- `H_ACTIVE`, 640: active pixels per line
- `V_START`, 35: line index (from frame start) of first active line
- `V_ACTIVE`, 480: active lines per frame
- `H_MAX`, 1023: line-length timeout, samples
- `V_MAX`, 1023: frame-length timeout, lines
- `LOCK_FRAMES`, 2: consecutive consistent frames required to lock

- `clk` in 1: pixel clock; all inputs synchronous to it
- `rst` in 1: asynchronous, active-low reset
- `hsync` in 1: active-low horizontal sync
- `vsync` in 1: active-low vertical sync
- `color_in` in 12: {R[3:0],G[3:0],B[3:0]}
- `pixel_valid` out 1: `x`/`y`/`color_out` hold an active pixel
- `x` out 10: active column 0..H_ACTIVE-1
- `y` out 10: active row 0..V_ACTIVE-1
- `color_out` out 12: registered `color_in` of that pixel
- `frame_start` out 1: one-cycle pulse coincident with pixel (0,0)
- `locked` out 1: stream qualified
- `h_total` out 11: last measured samples per line
- `v_total` out 10: last measured lines per frame

## Operation
- Inputs registered once (stage 1); edges detected on stage-1 values against their previous sample.
- Line start: hsync falling edge. That sample is h index 0. The counter increments per sample and saturates at 2047.
- Frame start: a line start at which stage-1 `vsync` is low while it was high at the previous line start. That line is v index 0. The line counter increments per line start.
- `h_total` is latched at each line start with the previous line's sample count. `v_total` is latched at each frame start with the previous frame's line count.
- A frame is consistent if every line in it has an equal `h_total` and no timeout occurred.
- FSM states:
  - SEARCH (reset state): waits for a frame start, then goes to TRAIN with `match_cnt=0`.
  - TRAIN: at each frame start:
    - If the completed frame is consistent and its `h_total`/`v_total` equal the prior frame's (or it is the first frame, so no comparison), then `match_cnt++`.
    - Otherwise `match_cnt=1` if consistent, else 0.
    - When `match_cnt==LOCK_FRAMES`, go to LOCKED.
  - LOCKED: leaves for SEARCH on any of:
    - a line whose length differs from the stored `h_total`;
    - a frame whose `v_total` differs;
    - h counter reaching H_MAX without a line start;
    - line counter reaching V_MAX without a frame start.
- Any transition to SEARCH or TRAIN clears `locked` the cycle after the detecting edge.
- Active pixel: h in [H_START, H_START+H_ACTIVE) and v in [V_START, V_START+V_ACTIVE) and state LOCKED. Then `x = h-H_START` and `y = v-V_START`.
- Outside active pixels, `x`/`y`/`color_out` hold their last values and `pixel_valid=0`.
- hsync and vsync falling on the same sample: the line start is processed first, and the vsync level check uses that same sample (the frame starts on that line).

## Timing
- Reset values: `pixel_valid=0`, `frame_start=0`, `locked=0`, `x=0`, `y=0`, `color_out=0`, `h_total=0`, `v_total=0`, FSM=SEARCH, counters=0.
- Latency: a `color_in` sample presented on cycle t appears on `color_out`, with its `pixel_valid`/`x`/`y`, at cycle t+2.
- `frame_start` is high exactly when `pixel_valid && x==0 && y==0`.
- `locked` rises at t+2, where t is the cycle on which hsync falls for the frame start that completes lock. Pixels of that frame's active region are then valid.
- `h_total`/`v_total` update at t+2 relative to the detecting hsync-fall sample.
- Reset mid-frame: all state clears immediately. After release, the block treats the stream as unknown and needs a frame start plus LOCK_FRAMES full frames to lock.

## Test plan
- Standard 800×525 stream (sync 96/2, V_START 35), `color_in={x[3:0],y[3:0],4'hA}`, reset released mid-frame. Required response:
  - `locked` rises at the third frame start after reset;
  - `h_total=800`, `v_total=525`;
  - exactly 307200 `pixel_valid` per frame;
  - every `color_out` matches its `x`/`y` with 2-cycle latency;
  - one `frame_start` per frame.
- While locked, one line shortened to 799 samples → `locked` falls 2 cycles after that line's ending hsync fall and `pixel_valid` stays 0. The block relocks after 2 further clean frames.
- While locked, hsync held high → `locked` falls when the h counter reaches 1023 samples after the last line start. No `pixel_valid` until relock.
- Frame with 526 lines inserted after lock → `locked` drops at that frame's end. `v_total=526`, then 525 on the next frame.
- Coincident hsync/vsync falling edge → that line is v index 0. First active row is line 35, with `y=0`.
- Asynchronous `rst` low mid-active-line → all outputs go to reset values within the same cycle. No `pixel_valid` until relock.
